vga_timing_gen: RTL and testbench

//  Downstream consumer of the test-pattern source. Generates 640x480@60 VGA raster timing:

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_timing_gen_sync_axis.sv | 53 +++++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, counter width and pixel word type
// for the VGA timing generator.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int CLK_DIV_DEF  = 2;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef logic [11:0] rgb444_t;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_axis.sv
// One raster axis: a wrapping position counter plus the sync and active
// decodes of the current position, used once per line and once per frame.
module vga_sync_axis
   import vga_timing_pkg::*;
#(
   parameter int   ACTIVE   = 640,
   parameter int   FP       = 16,
   parameter int   SYNC     = 96,
   parameter int   BP       = 48,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             sync_nxt,
   output logic             active_nxt
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   // One bit wider than the counter so a sync pulse ending at 1024 still compares correctly
   localparam logic [CNT_W:0] LAST       = (CNT_W+1)'(TOTAL - 1);
   localparam logic [CNT_W:0] ACT_END    = (CNT_W+1)'(ACTIVE);
   localparam logic [CNT_W:0] SYNC_START = (CNT_W+1)'(ACTIVE + FP);
   localparam logic [CNT_W:0] SYNC_END   = (CNT_W+1)'(ACTIVE + FP + SYNC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_ext;

   always_comb begin
      cnt_ext = {1'b0, cnt_q};
      wrap    = en && (cnt_ext == LAST);
      cnt_d   = cnt_q;
      if (en) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
      sync_nxt   = ((cnt_ext >= SYNC_START) && (cnt_ext < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      active_nxt = (cnt_ext < ACT_END);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v position counters and
// registered sync, blanking and RGB outputs lagging the counters by one pixel.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV  = CLK_DIV_DEF,
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  rgb444_t          pix_data,
   output logic             pix_tick,
   output logic [CNT_W-1:0] px_x,
   output logic [CNT_W-1:0] px_y,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output rgb444_t          rgb,
   output logic             frame_start
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_timing
         $error("vga_timing_gen: raster totals must be <= 1024 and CLK_DIV within 1..16");
      end
   endgenerate

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_tick_q, pix_tick_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             video_on_q, video_on_d;
   rgb444_t          rgb_q, rgb_d;

   logic h_wrap, h_sync_nxt, h_active_nxt;
   logic v_wrap, v_sync_nxt, v_active_nxt;

   vga_sync_axis #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
   ) u_h_axis (
      .clk(clk), .rst(rst), .en(pix_tick_q), .cnt(px_x),
      .wrap(h_wrap), .sync_nxt(h_sync_nxt), .active_nxt(h_active_nxt)
   );

   vga_sync_axis #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
   ) u_v_axis (
      .clk(clk), .rst(rst), .en(h_wrap & pix_tick_q), .cnt(px_y),
      .wrap(v_wrap), .sync_nxt(v_sync_nxt), .active_nxt(v_active_nxt)
   );

   // Outputs are loaded only on pixel ticks from the pre-advance position, so they trail px_x/px_y by one pixel
   always_comb begin
      div_d       = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      pix_tick_d  = (div_q == DIV_LAST);
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      video_on_d  = video_on_q;
      rgb_d       = rgb_q;
      if (pix_tick_q) begin
         hsync_d    = h_sync_nxt;
         vsync_d    = v_sync_nxt;
         video_on_d = h_active_nxt & v_active_nxt;
         rgb_d      = video_on_d ? pix_data : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= '0;
         pix_tick_q <= 1'b0;
         hsync_q    <= ~SYNC_POL;
         vsync_q    <= ~SYNC_POL;
         video_on_q <= 1'b0;
         rgb_q      <= '0;
      end else begin
         div_q      <= div_d;
         pix_tick_q <= pix_tick_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
         rgb_q      <= rgb_d;
      end
   end

   assign pix_tick    = pix_tick_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign rgb         = rgb_q;
   assign frame_start = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-pixel lines with a shortened
// 13-line frame (6/2/2/3) so whole frames fit in a short run, plus a CLK_DIV=1 instance.
module tb_vga_timing_gen;

   logic        clk;
   logic        rst;
   logic [11:0] pix_data;
   logic        pix_tick;
   logic [9:0]  px_x, px_y;
   logic        hsync, vsync, video_on, frame_start;
   logic [11:0] rgb;

   logic [11:0] pix_data1;
   logic        pix_tick1;
   logic [9:0]  px_x1, px_y1;
   logic        hsync1, vsync1, video_on1, frame_start1;
   logic [11:0] rgb1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int   x;
      int   y;
      logic hs;
      logic vs;
      logic vid;
   } vec_t;

   vec_t vecs[15];

   vga_timing_gen #(
      .CLK_DIV(2), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut (
      .clk(clk), .rst(rst), .pix_data(pix_data), .pix_tick(pix_tick),
      .px_x(px_x), .px_y(px_y), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .rgb(rgb), .frame_start(frame_start)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut1 (
      .clk(clk), .rst(rst), .pix_data(pix_data1), .pix_tick(pix_tick1),
      .px_x(px_x1), .px_y(px_y1), .hsync(hsync1), .vsync(vsync1),
      .video_on(video_on1), .rgb(rgb1), .frame_start(frame_start1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pattern source: present the word for the current coordinates well before the next edge
   initial begin
      pix_data = 12'h000;
      forever begin
         @(negedge clk);
         pix_data = {px_x[3:0], px_y[3:0], 4'hA};
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic abortRun(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait bound expired", name);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] aborted");
   endtask

   // Advance to the next clk in which pix_tick is high (sampled on the falling edge)
   task automatic stepTick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pix_tick !== 1'b1 && n < 40);
      if (pix_tick !== 1'b1) abortRun("tick_timeout");
   endtask

   task automatic findPixel(input int x, input int y);
      int n = 0;
      do begin
         stepTick();
         n++;
      end while (!(px_x == 10'(x) && px_y == 10'(y)) && n < 12000);
      if (!(px_x == 10'(x) && px_y == 10'(y))) abortRun("find_pixel_timeout");
   endtask

   task automatic checkResetState();
      checkOutput("rst_px_x", 32'(px_x), 0);
      checkOutput("rst_px_y", 32'(px_y), 0);
      checkOutput("rst_pix_tick", 32'(pix_tick), 0);
      checkOutput("rst_hsync", 32'(hsync), 1);
      checkOutput("rst_vsync", 32'(vsync), 1);
      checkOutput("rst_video_on", 32'(video_on), 0);
      checkOutput("rst_rgb", 32'(rgb), 0);
      checkOutput("rst_frame_start", 32'(frame_start), 0);
      checkOutput("rst_pix_tick_div1", 32'(pix_tick1), 0);
   endtask

   // Called on the falling edge where rst has just been dropped
   task automatic checkRestart();
      @(negedge clk);
      checkOutput("restart_tick_clk1", 32'(pix_tick), 0);
      checkOutput("restart_tick_div1_clk1", 32'(pix_tick1), 1);
      @(negedge clk);
      checkOutput("restart_tick_clk2", 32'(pix_tick), 1);
      checkOutput("restart_px_x_clk2", 32'(px_x), 0);
      @(negedge clk);
      checkOutput("restart_tick_clk3", 32'(pix_tick), 0);
      checkOutput("restart_px_x_clk3", 32'(px_x), 1);
      checkOutput("restart_px_y_clk3", 32'(px_y), 0);
   endtask

   task automatic applyStimulus();
      logic [9:0]  xx, yy;
      logic [11:0] exp_rgb;
      for (int i = 0; i < 15; i++) begin
         findPixel(vecs[i].x, vecs[i].y);
         stepTick();
         xx = 10'(vecs[i].x);
         yy = 10'(vecs[i].y);
         exp_rgb = vecs[i].vid ? {xx[3:0], yy[3:0], 4'hA} : 12'h000;
         checkOutput($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(vecs[i].hs));
         checkOutput($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(vecs[i].vs));
         checkOutput($sformatf("vec%0d_video_on", i), 32'(video_on), 32'(vecs[i].vid));
         checkOutput($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(exp_rgb));
      end
   endtask

   initial begin
      int vs_cnt, vs_first, fs_cnt, fs_k;
      int hs_cnt, hs_first, vid_cnt;
      int t_zero, hs1_cnt, n;

      vecs[0]  = '{639, 0,  1'b1, 1'b1, 1'b1};
      vecs[1]  = '{640, 0,  1'b1, 1'b1, 1'b0};
      vecs[2]  = '{655, 0,  1'b1, 1'b1, 1'b0};
      vecs[3]  = '{656, 0,  1'b0, 1'b1, 1'b0};
      vecs[4]  = '{751, 0,  1'b0, 1'b1, 1'b0};
      vecs[5]  = '{752, 0,  1'b1, 1'b1, 1'b0};
      vecs[6]  = '{799, 0,  1'b1, 1'b1, 1'b0};
      vecs[7]  = '{0,   1,  1'b1, 1'b1, 1'b1};
      vecs[8]  = '{5,   5,  1'b1, 1'b1, 1'b1};
      vecs[9]  = '{639, 5,  1'b1, 1'b1, 1'b1};
      vecs[10] = '{5,   6,  1'b1, 1'b1, 1'b0};
      vecs[11] = '{0,   8,  1'b1, 1'b0, 1'b0};
      vecs[12] = '{700, 9,  1'b0, 1'b0, 1'b0};
      vecs[13] = '{0,   10, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{799, 12, 1'b1, 1'b1, 1'b0};

      pix_data1 = 12'h5A5;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkResetState();
      rst = 1'b0;
      checkRestart();

      $display("[TB] pixel table");
      applyStimulus();

      $display("[TB] frame timing");
      checkOutput("frame_begin_px_x", 32'(px_x), 0);
      checkOutput("frame_begin_px_y", 32'(px_y), 0);
      vs_cnt = 0; vs_first = 0; fs_cnt = 0; fs_k = 0;
      for (int k = 1; k <= 10400; k++) begin
         stepTick();
         if (vsync == 1'b0) begin
            vs_cnt++;
            if (vs_first == 0) vs_first = k;
         end
         if (frame_start == 1'b1) begin
            fs_cnt++;
            fs_k = k;
         end
         if (k == 10399) begin
            checkOutput("frame_last_px_x", 32'(px_x), 799);
            checkOutput("frame_last_px_y", 32'(px_y), 12);
         end
      end
      checkOutput("vsync_low_ticks", 32'(vs_cnt), 1600);
      checkOutput("vsync_first_tick", 32'(vs_first), 6401);
      checkOutput("frame_start_count", 32'(fs_cnt), 1);
      checkOutput("frame_start_tick", 32'(fs_k), 10399);
      checkOutput("frame_wrap_px_x", 32'(px_x), 0);
      checkOutput("frame_wrap_px_y", 32'(px_y), 0);

      $display("[TB] line timing");
      hs_cnt = 0; hs_first = 0; vid_cnt = 0;
      for (int k = 1; k <= 800; k++) begin
         stepTick();
         if (hsync == 1'b0) begin
            hs_cnt++;
            if (hs_first == 0) hs_first = k;
         end
         if (video_on == 1'b1) vid_cnt++;
      end
      checkOutput("hsync_low_ticks", 32'(hs_cnt), 96);
      checkOutput("hsync_first_tick", 32'(hs_first), 657);
      checkOutput("video_on_ticks", 32'(vid_cnt), 640);
      checkOutput("line_end_px_x", 32'(px_x), 0);
      checkOutput("line_end_px_y", 32'(px_y), 1);

      $display("[TB] reset mid-frame");
      findPixel(700, 3);
      checkOutput("pre_reset_hsync", 32'(hsync), 0);
      rst = 1'b1;
      @(negedge clk);
      checkResetState();
      rst = 1'b0;
      checkRestart();
      findPixel(656, 0);
      stepTick();
      checkOutput("post_reset_hsync", 32'(hsync), 0);

      $display("[TB] CLK_DIV=1 instance");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (px_x1 != 10'd0 && n < 2000);
      if (px_x1 != 10'd0) abortRun("div1_line_start_timeout");
      t_zero = 0; hs1_cnt = 0;
      for (int k = 1; k <= 800; k++) begin
         @(negedge clk);
         if (pix_tick1 == 1'b0) t_zero++;
         if (hsync1 == 1'b0) hs1_cnt++;
      end
      checkOutput("div1_tick_gaps", 32'(t_zero), 0);
      checkOutput("div1_hsync_clks", 32'(hs1_cnt), 96);
      checkOutput("div1_line_len_px_x", 32'(px_x1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
